// File: rtl/profiler_pkg.sv
// Shared definitions for the instruction-class profiler.
// Holds the RV32 opcode and funct7 constants, the 12-value class enum,
// and a helper that maps an integer-ALU funct3 to its class.
package profiler_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_AMO    = 7'b0101111;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam int NUM_CLASSES = 12;

  typedef enum logic [3:0] {
    CLS_LOAD    = 4'd0,
    CLS_STORE   = 4'd1,
    CLS_ADD     = 4'd2,
    CLS_SUB     = 4'd3,
    CLS_LOGIC   = 4'd4,
    CLS_SHIFT   = 4'd5,
    CLS_COMPARE = 4'd6,
    CLS_BRANCH  = 4'd7,
    CLS_JUMP    = 4'd8,
    CLS_SYSTEM  = 4'd9,
    CLS_ATOMIC  = 4'd10,
    CLS_OTHER   = 4'd11
  } instr_class_e;

  // Integer ALU class from funct3 (OP with base funct7, or OP-IMM).
  function automatic instr_class_e alu_class(input logic [2:0] funct3);
    instr_class_e c;
    case (funct3)
      3'b000:         c = CLS_ADD;
      3'b001, 3'b101: c = CLS_SHIFT;
      3'b010, 3'b011: c = CLS_COMPARE;
      default:        c = CLS_LOGIC;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_classifier.sv
// Combinational single-instruction classifier.
// Ports:
//   instruction  in  32-bit RV32IA instruction word
//   instr_class  out class of that instruction (always exactly one)
module instr_classifier
  import profiler_pkg::*;
(
  input  logic [31:0]  instruction,
  output instr_class_e instr_class
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];
  // Register/immediate fields never influence the class.
  assign unused_fields = ^{instruction[24:15], instruction[11:7]};

  always_comb begin
    instr_class = CLS_OTHER;
    // Compressed encodings (inst[1:0] != 11) stay OTHER.
    if (instruction[1:0] == 2'b11) begin
      case (opcode)
        OPC_LOAD:   instr_class = CLS_LOAD;
        OPC_STORE:  instr_class = CLS_STORE;
        OPC_AUIPC:  instr_class = CLS_ADD;
        OPC_OP_IMM: instr_class = alu_class(funct3);
        OPC_OP: begin
          if (funct7 == F7_BASE) begin
            instr_class = alu_class(funct3);
          end else if (funct7 == F7_ALT) begin
            // Alternate funct7 only encodes SUB and SRA.
            if (funct3 == 3'b000)      instr_class = CLS_SUB;
            else if (funct3 == 3'b101) instr_class = CLS_SHIFT;
          end
          // M-extension (F7_MULDIV) and any other funct7 stay OTHER.
        end
        OPC_BRANCH:         instr_class = CLS_BRANCH;
        OPC_JAL, OPC_JALR:  instr_class = CLS_JUMP;
        OPC_SYSTEM:         instr_class = CLS_SYSTEM;
        OPC_AMO:            instr_class = CLS_ATOMIC;
        default:            instr_class = CLS_OTHER;
      endcase
    end
  end

endmodule

// File: rtl/instr_class_profiler_mp.sv
// Multi-issue instruction-class profiler.
// Classifies up to ISSUE_W issued instructions per cycle into 12 classes,
// accumulates per-class counters (wrap or saturate) with sticky overflow
// flags, and exposes an atomically captured shadow bank via a read port.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enable              1 = count, 0 = pause (counters hold)
//   clear               zero live counters and overflow flags
//   instruction         ISSUE_W packed 32-bit lanes, lane i at [32i+31:32i]
//   instruction_issued  per-lane issue strobe
//   snapshot_req        copy live bank into shadow bank
//   snapshot_done       one-cycle pulse the cycle after the copy
//   rd_req, rd_idx      read strobe and class index
//   rd_valid, rd_data, rd_ovf  registered read response from the shadow bank
//
// Read port: rd_req has no back-pressure (always accepted). rd_valid is
// high for exactly one cycle, the cycle after each rd_req, and rd_data /
// rd_ovf are meaningful only while rd_valid is high (zero otherwise).
module instr_class_profiler_mp
  import profiler_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int ISSUE_W  = 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [32*ISSUE_W-1:0]  instruction,
  input  logic [ISSUE_W-1:0]     instruction_issued,
  input  logic                   snapshot_req,
  output logic                   snapshot_done,
  input  logic                   rd_req,
  input  logic [3:0]             rd_idx,
  output logic                   rd_valid,
  output logic [CNT_W-1:0]       rd_data,
  output logic                   rd_ovf
);

  localparam int INC_W = $clog2(ISSUE_W + 1);
  localparam int SUM_W = CNT_W + 1;

  instr_class_e              lane_cls [ISSUE_W];
  instr_class_e              s1_cls_q [ISSUE_W];
  logic [ISSUE_W-1:0]        s1_vld_q;

  logic [INC_W-1:0]          inc      [NUM_CLASSES];
  logic [SUM_W-1:0]          sum      [NUM_CLASSES];
  logic [CNT_W-1:0]          cnt_q    [NUM_CLASSES];
  logic [NUM_CLASSES-1:0]    ovf_q;
  logic [CNT_W-1:0]          shd_cnt_q[NUM_CLASSES];
  logic [NUM_CLASSES-1:0]    shd_ovf_q;

  logic [CNT_W-1:0]          rd_sel_data;
  logic                      rd_sel_ovf;

  // Stage 1: per-lane decode.
  for (genvar l = 0; l < ISSUE_W; l++) begin : g_lane
    instr_classifier u_classifier (
      .instruction (instruction[32*l +: 32]),
      .instr_class (lane_cls[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= '0;
      for (int l = 0; l < ISSUE_W; l++) s1_cls_q[l] <= CLS_OTHER;
    end else begin
      // Pausing gates only new entries; stage 1 contents still commit.
      s1_vld_q <= instruction_issued & {ISSUE_W{enable}};
      for (int l = 0; l < ISSUE_W; l++) s1_cls_q[l] <= lane_cls[l];
    end
  end

  // Stage 2: per-class lane count and widened add (carry-out = overflow).
  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      inc[c] = '0;
      for (int l = 0; l < ISSUE_W; l++) begin
        if (s1_vld_q[l] && (s1_cls_q[l] == instr_class_e'(c))) begin
          inc[c] = inc[c] + INC_W'(1);
        end
      end
      sum[c] = {1'b0, cnt_q[c]} + SUM_W'(inc[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      // Clear drops the increment landing on this edge.
      ovf_q <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        if (sum[c][CNT_W]) begin
          ovf_q[c] <= 1'b1;
          cnt_q[c] <= SATURATE ? {CNT_W{1'b1}} : sum[c][CNT_W-1:0];
        end else begin
          cnt_q[c] <= sum[c][CNT_W-1:0];
        end
      end
    end
  end

  // Shadow bank captures the live registers as held before the edge,
  // so a coincident clear or increment is not seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      shd_ovf_q     <= '0;
      snapshot_done <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) shd_cnt_q[c] <= '0;
    end else begin
      snapshot_done <= snapshot_req;
      if (snapshot_req) begin
        shd_ovf_q <= ovf_q;
        for (int c = 0; c < NUM_CLASSES; c++) shd_cnt_q[c] <= cnt_q[c];
      end
    end
  end

  // Indices 12..15 match nothing and read as zero.
  always_comb begin
    rd_sel_data = '0;
    rd_sel_ovf  = 1'b0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (rd_idx == 4'(c)) begin
        rd_sel_data = shd_cnt_q[c];
        rd_sel_ovf  = shd_ovf_q[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_ovf   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      rd_data  <= rd_req ? rd_sel_data : '0;
      rd_ovf   <= rd_req ? rd_sel_ovf  : 1'b0;
    end
  end

endmodule
